// File: rtl/wsg_pkg.sv
// Shared definitions for the multi-voice wavetable sound generator:
// register slot offsets, the sweep FSM state type and a clog2 helper.
package wsg_pkg;

  // Per-channel register slots (low three address bits).
  localparam logic [2:0] FREQ0 = 3'd0;
  localparam logic [2:0] FREQ1 = 3'd1;
  localparam logic [2:0] FREQ2 = 3'd2;
  localparam logic [2:0] FREQ3 = 3'd3;
  localparam logic [2:0] FREQ4 = 3'd4;
  localparam logic [2:0] WAVE  = 3'd5;
  localparam logic [2:0] VOL   = 3'd6;

  // Sample sweep sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    OUT
  } state_t;

  // Number of bits needed to index n items (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/wsg_regfile.sv
// Voice register file: frequency, waveform and volume per channel.
// Nibble-wide write port on CPUCLK, channel-indexed combinational read
// port that feeds the shared sweep datapath.
module wsg_regfile
  import wsg_pkg::*;
#(
  parameter int NCH = 8,
  parameter int FW  = 20,
  parameter int CW  = 3
) (
  input  logic          CPUCLK,
  input  logic          RESET,
  input  logic          WR,
  input  logic [CW+2:0] ADRS,
  input  logic [3:0]    DATA,
  input  logic [CW-1:0] rd_ch,
  output logic [FW-1:0] rd_freq,
  output logic [2:0]    rd_wave,
  output logic [3:0]    rd_vol
);

  logic [FW-1:0] freq [NCH];
  logic [2:0]    wave [NCH];
  logic [3:0]    vol  [NCH];

  logic [CW-1:0] wr_ch;
  logic [2:0]    wr_slot;
  logic          wr_ok;
  logic [19:0]   freq_wide;
  logic [FW-1:0] freq_new;

  assign wr_ch   = ADRS[CW+2:3];
  assign wr_slot = ADRS[2:0];
  assign wr_ok   = WR && (int'(wr_ch) < NCH);

  // Merge the written nibble into a 20-bit view of the frequency, then drop bits at or above FW.
  always_comb begin
    // NOTE: every variable gets its default before the case, so no path can infer a latch.
    freq_wide = 20'(freq[wr_ch]);
    case (wr_slot)
      FREQ0:   freq_wide[3:0]   = DATA;
      FREQ1:   freq_wide[7:4]   = DATA;
      FREQ2:   freq_wide[11:8]  = DATA;
      FREQ3:   freq_wide[15:12] = DATA;
      FREQ4:   freq_wide[19:16] = DATA;
      default: ;
    endcase
    freq_new = freq_wide[FW-1:0];
  end

  // Register writes; the whole file clears on RESET.
  always_ff @(posedge CPUCLK or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (RESET) begin
      // NOTE: this storage is built from flops rather than a RAM macro, so it can and must be reset.
      for (int i = 0; i < NCH; i++) begin
        freq[i] <= '0;
        wave[i] <= '0;
        vol[i]  <= '0;
      end
    end else if (wr_ok) begin
      case (wr_slot)
        FREQ0, FREQ1, FREQ2, FREQ3, FREQ4: freq[wr_ch] <= freq_new;
        WAVE:    wave[wr_ch] <= DATA[2:0];
        VOL:     vol[wr_ch]  <= DATA;
        default: ;
      endcase
    end
  end

  // Read port sees the pre-write value during a same-cycle write.
  assign rd_freq = freq[rd_ch];
  assign rd_wave = wave[rd_ch];
  assign rd_vol  = vol[rd_ch];

endmodule

// File: rtl/wsg_multi.sv
// Multi-voice wavetable sound generator. On each sample tick the
// sequencer sweeps the voices one per cycle through a single shared
// phase adder and a single multiply-accumulate, then saturates the mix
// into an 8-bit unsigned sample.
module wsg_multi
  import wsg_pkg::*;
#(
  parameter int  NCH   = 8,
  parameter int  FW    = 20,
  parameter int  SHIFT = 2,
  localparam int CW    = clog2(NCH)
) (
  input  logic          CPUCLK,
  input  logic          RESET,
  input  logic [CW+2:0] ADRS,
  input  logic [3:0]    DATA,
  input  logic          WR,
  input  logic          SMPEN,
  output logic [7:0]    WROMADR,
  input  logic [3:0]    WROMDAT,
  output logic [7:0]    PCMOUT,
  output logic          PCMVALID,
  output logic          BUSY
);

  localparam int            MW      = 8 + CW;
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] ch;
  logic [FW-1:0] acc [NCH];

  logic [FW-1:0] rd_freq;
  logic [2:0]    rd_wave;
  logic [3:0]    rd_vol;

  logic [FW-1:0] acc_sum;
  logic [3:0]    vol_eff;
  logic [3:0]    vol_d;
  logic [7:0]    prod;
  logic [MW-1:0] mix;
  logic [MW-1:0] mix_sum;
  logic [MW-1:0] mix_shr;
  logic [7:0]    pcm_sat;

  logic start;
  logic sweep;
  logic accum;
  logic drain;

  wsg_regfile #(
    .NCH (NCH),
    .FW  (FW),
    .CW  (CW)
  ) u_regfile (
    .CPUCLK  (CPUCLK),
    .RESET   (RESET),
    .WR      (WR),
    .ADRS    (ADRS),
    .DATA    (DATA),
    .rd_ch   (ch),
    .rd_freq (rd_freq),
    .rd_wave (rd_wave),
    .rd_vol  (rd_vol)
  );

  // Shared datapath: one phase adder, one multiplier, one mix adder and the output saturator.
  always_comb begin
    acc_sum = acc[ch] + rd_freq;
    vol_eff = (rd_freq == '0) ? 4'd0 : rd_vol;
    prod    = {4'd0, vol_d} * {4'd0, WROMDAT};
    mix_sum = mix + MW'(prod);
    mix_shr = mix_sum >> SHIFT;
    pcm_sat = (mix_shr > MW'(255)) ? 8'hFF : mix_shr[7:0];
  end

  // Sequencer state register.
  always_ff @(posedge CPUCLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Sequencer next state; SMPEN is only looked at in IDLE, so ticks during a sweep are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (SMPEN) state_nxt = SWEEP;
      SWEEP:   if (ch == LAST_CH) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer outputs and datapath enables decoded from the current state.
  always_comb begin
    BUSY     = (state != IDLE);
    PCMVALID = (state == OUT);
    start    = (state == IDLE) && SMPEN;
    sweep    = (state == SWEEP);
    accum    = (state == SWEEP) || (state == DRAIN);
    drain    = (state == DRAIN);
  end

  // Channel counter: walks 0..NCH-1 during SWEEP, parked at 0 otherwise.
  always_ff @(posedge CPUCLK or posedge RESET) begin
    if (RESET)                     ch <= '0;
    else if (sweep && ch != LAST_CH) ch <= ch + 1'b1;
    else                           ch <= '0;
  end

  // Phase accumulators: only the swept channel advances, and only during SWEEP.
  always_ff @(posedge CPUCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
    end else if (sweep) begin
      acc[ch] <= acc_sum;
    end
  end

  // Wave ROM address issued from the new phase; holds outside SWEEP.
  always_ff @(posedge CPUCLK or posedge RESET) begin
    if (RESET)      WROMADR <= '0;
    else if (sweep) WROMADR <= {rd_wave, acc_sum[FW-1 -: 5]};
  end

  // Volume delayed one cycle to line up with the ROM datum; zero when no address was issued.
  always_ff @(posedge CPUCLK or posedge RESET) begin
    if (RESET) vol_d <= '0;
    else       vol_d <= sweep ? vol_eff : 4'd0;
  end

  // Mix accumulator: cleared at sweep start, accumulates through SWEEP and DRAIN.
  always_ff @(posedge CPUCLK or posedge RESET) begin
    if (RESET)      mix <= '0;
    else if (start) mix <= '0;
    else if (accum) mix <= mix_sum;
  end

  // Output sample: loaded with the saturated final mix as the sequencer enters OUT.
  always_ff @(posedge CPUCLK or posedge RESET) begin
    if (RESET)      PCMOUT <= '0;
    else if (drain) PCMOUT <= pcm_sat;
  end

endmodule

// File: tb/tb_wsg_multi.sv
// Self-checking bench for wsg_multi (NCH=8, FW=20, SHIFT=2).
// The wave ROM model answers combinationally from the registered
// address, with data = addr[3:0] or a constant 0xF.
module tb_wsg_multi;

  localparam int NCH = 8;
  localparam int FW  = 20;
  localparam int CW  = 3;

  logic          CPUCLK = 1'b0;
  logic          RESET;
  logic [CW+2:0] ADRS;
  logic [3:0]    DATA;
  logic          WR;
  logic          SMPEN;
  logic [7:0]    WROMADR;
  logic [3:0]    WROMDAT;
  logic [7:0]    PCMOUT;
  logic          PCMVALID;
  logic          BUSY;

  bit            rom_const;
  logic [7:0]    adr_seen [NCH];
  logic [10:0]   mix_seen;

  int checks = 0;
  int errors = 0;

  wsg_multi #(
    .NCH   (NCH),
    .FW    (FW),
    .SHIFT (2)
  ) dut (
    .CPUCLK   (CPUCLK),
    .RESET    (RESET),
    .ADRS     (ADRS),
    .DATA     (DATA),
    .WR       (WR),
    .SMPEN    (SMPEN),
    .WROMADR  (WROMADR),
    .WROMDAT  (WROMDAT),
    .PCMOUT   (PCMOUT),
    .PCMVALID (PCMVALID),
    .BUSY     (BUSY)
  );

  always #5 CPUCLK = ~CPUCLK;

  assign WROMDAT = rom_const ? 4'hF : WROMADR[3:0];

  typedef struct {
    int         ch;
    logic [19:0] freq;
    logic [2:0] wave;
    logic [3:0] vol;
    int         nsamp;
    logic [7:0] exp_pcm;
    logic [7:0] exp_adr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CPUCLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    WR    = 1'b0;
    SMPEN = 1'b0;
    ADRS  = '0;
    DATA  = '0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic wr(input int ch, input logic [2:0] slot, input logic [3:0] d);
    ADRS = {3'(ch), slot};
    DATA = d;
    WR   = 1'b1;
    tick();
    WR   = 1'b0;
  endtask

  task automatic program_ch(input int ch, input logic [19:0] f, input logic [2:0] w, input logic [3:0] v);
    for (int k = 0; k < 5; k++) wr(ch, 3'(k), f[4*k +: 4]);
    wr(ch, 3'd5, {1'b1, w});
    wr(ch, 3'd6, v);
    wr(ch, 3'd7, 4'hF);
  endtask

  // One sample tick; optional register write during channel 0's sweep cycle.
  // lat = cycles from the SMPEN cycle to the PCMVALID cycle, -1 on timeout.
  task automatic run_sample(input bit inj, input logic [5:0] ia, input logic [3:0] id,
                            output int lat, output logic [7:0] pcm);
    lat   = -1;
    pcm   = 'x;
    SMPEN = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      SMPEN = 1'b0;
      WR    = 1'b0;
      if (t >= 2 && t <= NCH + 1) adr_seen[t-2] = WROMADR;
      if (PCMVALID) begin
        lat      = t;
        pcm      = PCMOUT;
        mix_seen = dut.mix;
        break;
      end
      if (t == 1 && inj) begin
        WR   = 1'b1;
        ADRS = ia;
        DATA = id;
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] pcm;
    int         busy_cnt;
    int         pv_cnt;

    vecs[0] = '{0, 20'h08000, 3'd0, 4'd15,  1, 8'd3,  8'h01};
    vecs[1] = '{5, 20'h10000, 3'd2, 4'd8,   3, 8'd12, 8'h46};
    vecs[2] = '{7, 20'hFFFFF, 3'd7, 4'd15,  1, 8'd56, 8'hFF};
    vecs[3] = '{2, 20'h08000, 3'd3, 4'd0,   2, 8'd0,  8'h62};
    vecs[4] = '{1, 20'hF8000, 3'd1, 4'd15,  2, 8'd52, 8'h3E};
    vecs[5] = '{6, 20'h04000, 3'd0, 4'd4,   6, 8'd3,  8'h03};
    vecs[6] = '{4, 20'h08000, 3'd6, 4'd9,  13, 8'd29, 8'hCD};

    rom_const = 1'b0;
    RESET = 1'b1;
    WR    = 1'b0;
    SMPEN = 1'b0;
    ADRS  = '0;
    DATA  = '0;
    #12;
    check("reset_pcmout",   32'(PCMOUT),   32'h0);
    check("reset_pcmvalid", 32'(PCMVALID), 32'h0);
    check("reset_busy",     32'(BUSY),     32'h0);
    check("reset_wromadr",  32'(WROMADR),  32'h0);

    // Single-voice vectors.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      program_ch(vecs[i].ch, vecs[i].freq, vecs[i].wave, vecs[i].vol);
      for (int s = 0; s < vecs[i].nsamp; s++) run_sample(1'b0, '0, '0, lat, pcm);
      check($sformatf("row%0d_pcm", i), 32'(pcm), 32'(vecs[i].exp_pcm));
      check($sformatf("row%0d_adr", i), 32'(adr_seen[vecs[i].ch]), 32'(vecs[i].exp_adr));
      check($sformatf("row%0d_lat", i), 32'(lat), 32'd10);
    end

    // Ramp over four samples on channel 0.
    do_reset();
    program_ch(0, 20'h08000, 3'd0, 4'd15);
    for (int s = 1; s <= 4; s++) begin
      run_sample(1'b0, '0, '0, lat, pcm);
      check($sformatf("ramp%0d_pcm", s), 32'(pcm), 32'(4 * s - 1));
      check($sformatf("ramp%0d_lat", s), 32'(lat), 32'd10);
    end

    // Zero frequency gates the volume; phase never moves.
    do_reset();
    rom_const = 1'b1;
    program_ch(3, 20'h00000, 3'd5, 4'd15);
    for (int s = 1; s <= 5; s++) begin
      run_sample(1'b0, '0, '0, lat, pcm);
      check($sformatf("f0_%0d_pcm", s), 32'(pcm), 32'h0);
      check($sformatf("f0_%0d_adr", s), 32'(adr_seen[3]), 32'hA0);
    end

    // All voices at full volume on a constant-F ROM: saturation.
    do_reset();
    for (int c = 0; c < NCH; c++) program_ch(c, 20'h00001, 3'(c), 4'd15);
    run_sample(1'b0, '0, '0, lat, pcm);
    check("sat_pcm", 32'(pcm), 32'hFF);
    check("sat_mix", 32'(mix_seen), 32'd1800);
    rom_const = 1'b0;

    // Second SMPEN during a sweep is dropped.
    do_reset();
    program_ch(0, 20'h08000, 3'd0, 4'd15);
    busy_cnt = 0;
    pv_cnt   = 0;
    SMPEN = 1'b1;
    tick();
    for (int t = 1; t <= 30; t++) begin
      if (BUSY) busy_cnt++;
      if (PCMVALID) pv_cnt++;
      SMPEN = (t == 3);
      tick();
    end
    SMPEN = 1'b0;
    check("dbl_pcmvalid_count", 32'(pv_cnt), 32'd1);
    check("dbl_busy_cycles",    32'(busy_cnt), 32'd10);

    // Write to channel 0 during its own sweep cycle: old value now, new value next sample.
    do_reset();
    program_ch(0, 20'h08000, 3'd0, 4'd15);
    run_sample(1'b1, {3'd0, 3'd4}, 4'h1, lat, pcm);
    check("wrsweep_s1_pcm", 32'(pcm), 32'd3);
    run_sample(1'b0, '0, '0, lat, pcm);
    check("wrsweep_s2_pcm", 32'(pcm), 32'd15);
    check("wrsweep_s2_adr", 32'(adr_seen[0]), 32'h04);

    // Reset in the middle of a sweep.
    do_reset();
    program_ch(0, 20'h08000, 3'd0, 4'd15);
    program_ch(3, 20'h08000, 3'd7, 4'd15);
    run_sample(1'b0, '0, '0, lat, pcm);
    check("prerst_pcm", 32'(pcm), 32'd7);
    SMPEN = 1'b1;
    tick();
    SMPEN = 1'b0;
    for (int t = 2; t <= 5; t++) tick();
    check("prerst_busy",    32'(BUSY),    32'h1);
    check("prerst_wromadr", 32'(WROMADR), 32'hE2);
    RESET = 1'b1;
    #1;
    check("midrst_pcmout",   32'(PCMOUT),   32'h0);
    check("midrst_pcmvalid", 32'(PCMVALID), 32'h0);
    check("midrst_busy",     32'(BUSY),     32'h0);
    check("midrst_wromadr",  32'(WROMADR),  32'h0);
    tick();
    RESET = 1'b0;
    tick();
    run_sample(1'b0, '0, '0, lat, pcm);
    check("postrst_pcm",  32'(pcm), 32'h0);
    check("postrst_lat",  32'(lat), 32'd10);
    check("postrst_adr0", 32'(adr_seen[0]), 32'h0);
    check("postrst_adr3", 32'(adr_seen[3]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
